// File: rtl/axi_ni_target_wdata_unpacker.sv
// Target NI write-data unpacker: buffers NoC payload words and replays them as an AXI W burst.
// Optional build macro NI_TGT_WDATA_MASK_EN zeroes WDATA bytes whose WSTRB bit is clear.

`ifndef LITTLE_ENDIAN
`define LITTLE_ENDIAN 0
`endif

module axi_ni_target_wdata_unpacker #(
  parameter int AXIWDATAWD = 32,
  parameter int BEWD       = AXIWDATAWD / 8,
  parameter int DEPTH      = 4,
  parameter int BURSTLENWD = 8,
  parameter int ENDIANNESS = `LITTLE_ENDIAN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BURSTLENWD-1:0] burst_len,
  output logic                  busy,
  input  logic                  payload_valid,
  input  logic [AXIWDATAWD-1:0] payload_data,
  input  logic [BEWD-1:0]       payload_ben,
  output logic                  payload_ready,
  output logic                  WVALID,
  output logic [AXIWDATAWD-1:0] WDATA,
  output logic [BEWD-1:0]       WSTRB,
  output logic                  WLAST,
  input  logic                  WREADY,
  output logic                  burst_done
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [BURSTLENWD-1:0] CNT_ONE = BURSTLENWD'(1);
  localparam logic [AW:0]           PTR_ONE = (AW + 1)'(1);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic [BURSTLENWD-1:0] in_left;
  logic [BURSTLENWD-1:0] out_left;
  logic                  in_pending;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic [AXIWDATAWD-1:0] mem_data [DEPTH];
  logic [BEWD-1:0]       mem_ben  [DEPTH];

  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  push;
  logic                  pop;
  logic                  start_burst;
  logic [AXIWDATAWD-1:0] ord_data;
  logic [AXIWDATAWD-1:0] wr_data;
  logic [BEWD-1:0]       ord_ben;

  // Reorder from NoC (little-endian) lanes into slave lanes before the FIFO.
  for (genvar i = 0; i < BEWD; i++) begin : g_lane
    localparam int SRC = (ENDIANNESS == `LITTLE_ENDIAN) ? i : (BEWD - 1 - i);
    assign ord_data[8*i +: 8] = payload_data[8*SRC +: 8];
    assign ord_ben[i]         = payload_ben[SRC];
`ifdef NI_TGT_WDATA_MASK_EN
    assign wr_data[8*i +: 8]  = ord_ben[i] ? ord_data[8*i +: 8] : 8'h00;
`else
    assign wr_data[8*i +: 8]  = ord_data[8*i +: 8];
`endif
  end

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign start_burst   = (state == IDLE) && start;
  assign payload_ready = (state == STREAM) && in_pending && !fifo_full;
  assign push          = payload_valid && payload_ready;

  // W outputs are gated by WVALID so they read zero whenever no beat is offered.
  assign WVALID = (state == STREAM) && !fifo_empty;
  assign WDATA  = WVALID ? mem_data[rd_ptr[AW-1:0]] : '0;
  assign WSTRB  = WVALID ? mem_ben[rd_ptr[AW-1:0]]  : '0;
  assign WLAST  = WVALID && (out_left == '0);
  assign pop    = WVALID && WREADY;

  assign busy       = (state != IDLE);
  assign burst_done = (state == DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = STREAM;
      STREAM:  if (pop && WLAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The push taken at in_left==0 is the final word; counters saturate at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_left    <= '0;
      out_left   <= '0;
      in_pending <= 1'b0;
    end else if (start_burst) begin
      in_left    <= burst_len;
      out_left   <= burst_len;
      in_pending <= 1'b1;
    end else begin
      if (push) begin
        if (in_left == '0) begin
          in_pending <= 1'b0;
        end else begin
          in_left <= in_left - CNT_ONE;
        end
      end
      if (pop && (out_left != '0)) begin
        out_left <= out_left - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (start_burst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr[AW-1:0]] <= wr_data;
      mem_ben[wr_ptr[AW-1:0]]  <= ord_ben;
    end
  end

endmodule

// File: tb/tb_axi_ni_target_wdata_unpacker.sv
// Bench for axi_ni_target_wdata_unpacker: little- and big-endian instances share stimulus and
// are checked every cycle against a queue-based model, plus hand-computed directed expectations.

module tb_axi_ni_target_wdata_unpacker;

  localparam int W     = 32;
  localparam int BE    = 4;
  localparam int DEPTH = 4;
  localparam int BLW   = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start = 1'b0;
  logic [BLW-1:0] burst_len = '0;
  logic           payload_valid = 1'b0;
  logic [W-1:0]   payload_data = '0;
  logic [BE-1:0]  payload_ben = '0;
  logic           WREADY = 1'b0;

  logic           busy_le, ready_le, wvalid_le, wlast_le, done_le;
  logic [W-1:0]   wdata_le;
  logic [BE-1:0]  wstrb_le;
  logic           busy_be, ready_be, wvalid_be, wlast_be, done_be;
  logic [W-1:0]   wdata_be;
  logic [BE-1:0]  wstrb_be;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  axi_ni_target_wdata_unpacker #(
    .AXIWDATAWD(W), .BEWD(BE), .DEPTH(DEPTH), .BURSTLENWD(BLW)
  ) dut_le (
    .clk(clk), .rst(rst), .start(start), .burst_len(burst_len), .busy(busy_le),
    .payload_valid(payload_valid), .payload_data(payload_data), .payload_ben(payload_ben),
    .payload_ready(ready_le), .WVALID(wvalid_le), .WDATA(wdata_le), .WSTRB(wstrb_le),
    .WLAST(wlast_le), .WREADY(WREADY), .burst_done(done_le)
  );

  axi_ni_target_wdata_unpacker #(
    .AXIWDATAWD(W), .BEWD(BE), .DEPTH(DEPTH), .BURSTLENWD(BLW), .ENDIANNESS(1)
  ) dut_be (
    .clk(clk), .rst(rst), .start(start), .burst_len(burst_len), .busy(busy_be),
    .payload_valid(payload_valid), .payload_data(payload_data), .payload_ben(payload_ben),
    .payload_ready(ready_be), .WVALID(wvalid_be), .WDATA(wdata_be), .WSTRB(wstrb_be),
    .WLAST(wlast_be), .WREADY(WREADY), .burst_done(done_be)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Payload source: offers table words until src_limit words have been taken.
  logic [W-1:0]  tab_d [16];
  logic [BE-1:0] tab_b [16];
  int src_start = 0;
  int src_limit = 0;
  int src_taken = 0;

  initial begin
    forever begin
      @(posedge clk);
      if (payload_valid && ready_le) src_taken++;
      #2;
      payload_valid = (src_taken < src_limit);
      payload_data  = tab_d[(src_taken - src_start) % 16];
      payload_ben   = tab_b[(src_taken - src_start) % 16];
    end
  end

  // Handshake counters observed at the clock edge.
  int push_cnt = 0;
  int beat_cnt = 0;
  int last_at  = 0;
  int done_cnt = 0;

  initial begin
    forever begin
      @(posedge clk);
      if (payload_valid && ready_le) push_cnt++;
      if (wvalid_le && WREADY) begin
        beat_cnt++;
        if (wlast_le) last_at = beat_cnt;
      end
      if (done_le) done_cnt++;
    end
  end

  // Behavioural model: a burst owes burst_len+1 words in and burst_len+1 beats out.
  typedef struct packed {
    logic [W-1:0]  d;
    logic [BE-1:0] s;
  } beat_t;

  beat_t q_le[$];
  beat_t q_be[$];
  bit    m_active = 1'b0;
  bit    m_done = 1'b0;
  int    m_words = 0;
  int    m_beats = 0;

  function automatic beat_t to_slave(input logic [W-1:0] d, input logic [BE-1:0] b, input bit big);
    beat_t r;
    for (int k = 0; k < BE; k++) begin
      int src;
      src = big ? (BE - 1 - k) : k;
      r.d[8*k +: 8] = d[8*src +: 8];
      r.s[k]        = b[src];
`ifdef NI_TGT_WDATA_MASK_EN
      if (!r.s[k]) r.d[8*k +: 8] = 8'h00;
`endif
    end
    return r;
  endfunction

  function automatic bit exp_ready();
    return m_active && (m_words > 0) && (q_le.size() < DEPTH);
  endfunction

  function automatic bit exp_wvalid();
    return m_active && (q_le.size() > 0);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_active = 1'b0;
      m_done   = 1'b0;
      m_words  = 0;
      m_beats  = 0;
      q_le.delete();
      q_be.delete();
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (!m_active) begin
      if (start) begin
        m_active = 1'b1;
        m_words  = int'(burst_len) + 1;
        m_beats  = int'(burst_len) + 1;
        q_le.delete();
        q_be.delete();
      end
    end else begin
      bit do_push;
      bit do_pop;
      do_push = payload_valid && exp_ready();
      do_pop  = exp_wvalid() && WREADY;
      if (do_pop) begin
        void'(q_le.pop_front());
        void'(q_be.pop_front());
        m_beats--;
        if (m_beats == 0) begin
          m_active = 1'b0;
          m_done   = 1'b1;
        end
      end
      if (do_push) begin
        q_le.push_back(to_slave(payload_data, payload_ben, 1'b0));
        q_be.push_back(to_slave(payload_data, payload_ben, 1'b1));
        m_words--;
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  initial begin
    forever begin
      logic          ev;
      logic [W-1:0]  ed_le, ed_be;
      logic [BE-1:0] es_le, es_be;
      @(negedge clk);
      ev = exp_wvalid();
      ed_le = '0; es_le = '0; ed_be = '0; es_be = '0;
      if (ev) begin
        ed_le = q_le[0].d; es_le = q_le[0].s;
        ed_be = q_be[0].d; es_be = q_be[0].s;
      end
      checkOutput("busy_le",   busy_le,   m_active || m_done);
      checkOutput("ready_le",  ready_le,  exp_ready());
      checkOutput("wvalid_le", wvalid_le, ev);
      checkOutput("wdata_le",  wdata_le,  ed_le);
      checkOutput("wstrb_le",  wstrb_le,  es_le);
      checkOutput("wlast_le",  wlast_le,  ev && (m_beats == 1));
      checkOutput("done_le",   done_le,   m_done);
      checkOutput("busy_be",   busy_be,   m_active || m_done);
      checkOutput("ready_be",  ready_be,  exp_ready());
      checkOutput("wvalid_be", wvalid_be, ev);
      checkOutput("wdata_be",  wdata_be,  ed_be);
      checkOutput("wstrb_be",  wstrb_be,  es_be);
      checkOutput("wlast_be",  wlast_be,  ev && (m_beats == 1));
      checkOutput("done_be",   done_be,   m_done);
    end
  end

  int push_base, beat_base, done_base;

  task automatic applyStimulus(input int bl, input int nwords, input logic wr);
    @(posedge clk);
    #1;
    push_base = push_cnt;
    beat_base = beat_cnt;
    done_base = done_cnt;
    src_start = src_taken;
    src_limit = src_taken + nwords;
    WREADY    = wr;
    start     = 1'b1;
    burst_len = BLW'(bl);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic waitDone(input int limit);
    int n;
    n = 0;
    while ((done_cnt == done_base) && (n < limit)) begin
      @(negedge clk);
      n++;
    end
    checkOutput("done_seen", done_cnt != done_base, 1);
  endtask

  task automatic waitWvalid(input int limit);
    int n;
    n = 0;
    while (!wvalid_le && (n < limit)) begin
      @(negedge clk);
      n++;
    end
    checkOutput("wvalid_seen", wvalid_le, 1);
  endtask

  task automatic checkBurst(input string tag, input int pushes, input int beats, input int last);
    checkOutput({tag, "_pushes"}, push_cnt - push_base, pushes);
    checkOutput({tag, "_beats"}, beat_cnt - beat_base, beats);
    checkOutput({tag, "_wlast_pos"}, last_at - beat_base, last);
    checkOutput({tag, "_done_pulses"}, done_cnt - done_base, 1);
  endtask

  initial begin
    int n;
    #100000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    for (int k = 0; k < 16; k++) begin
      tab_d[k] = '0;
      tab_b[k] = '0;
    end

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", busy_le, 0);
    checkOutput("rst_ready", ready_le, 0);
    checkOutput("rst_wvalid", wvalid_le, 0);
    checkOutput("rst_wdata", wdata_le, 0);
    checkOutput("rst_wstrb", wstrb_le, 0);
    checkOutput("rst_wlast", wlast_le, 0);
    checkOutput("rst_done", done_le, 0);
    @(posedge clk);
    #1 rst = 1'b1;

    // Single beat, little-endian
    tab_d[0] = 32'h11223344; tab_b[0] = 4'hF;
    applyStimulus(0, 1, 1'b1);
    waitWvalid(10);
    checkOutput("single_wdata", wdata_le, 32'h11223344);
    checkOutput("single_wstrb", wstrb_le, 4'hF);
    checkOutput("single_wlast", wlast_le, 1);
    @(negedge clk);
    checkOutput("single_done", done_le, 1);
    @(negedge clk);
    checkOutput("single_done_drop", done_le, 0);
    checkOutput("single_idle", busy_le, 0);

    // Byte reorder on the big-endian instance
    tab_d[0] = 32'hAABBCCDD; tab_b[0] = 4'h3;
    applyStimulus(0, 1, 1'b1);
    waitWvalid(10);
`ifdef NI_TGT_WDATA_MASK_EN
    checkOutput("be_wdata", wdata_be, 32'hDDCC0000);
    checkOutput("le_wdata", wdata_le, 32'h0000CCDD);
`else
    checkOutput("be_wdata", wdata_be, 32'hDDCCBBAA);
    checkOutput("le_wdata", wdata_le, 32'hAABBCCDD);
`endif
    checkOutput("be_wstrb", wstrb_be, 4'hC);
    checkOutput("le_wstrb", wstrb_le, 4'h3);
    waitDone(10);

    // Back-pressure: eight beats, slave stalled
    for (int k = 0; k < 8; k++) begin
      tab_d[k] = 32'hC0DE0000 | (k << 8) | k;
      tab_b[k] = 4'hF;
    end
    applyStimulus(7, 8, 1'b0);
    repeat (10) @(negedge clk);
    checkOutput("bp_pushes_full", push_cnt - push_base, 4);
    checkOutput("bp_ready_low", ready_le, 0);
    checkOutput("bp_wdata_head", wdata_le, 32'hC0DE0000);
    repeat (3) @(negedge clk);
    checkOutput("bp_wdata_hold", wdata_le, 32'hC0DE0000);
    checkOutput("bp_wlast_hold", wlast_le, 0);
    @(posedge clk);
    #1 WREADY = 1'b1;
    waitDone(40);
    checkBurst("bp", 8, 8, 8);

    // Over-supply: more words offered than the burst needs
    for (int k = 0; k < 6; k++) begin
      tab_d[k] = 32'h5A5A0000 + k;
      tab_b[k] = 4'(k + 5);
    end
    applyStimulus(2, 6, 1'b1);
    waitDone(30);
    checkBurst("over", 3, 3, 3);
    @(negedge clk);
    checkOutput("over_ready_low", ready_le, 0);
    src_limit = src_taken;

    // Reset mid-burst
    for (int k = 0; k < 4; k++) begin
      tab_d[k] = 32'h0BAD0000 + (k * 32'h11);
      tab_b[k] = 4'hF;
    end
    applyStimulus(3, 4, 1'b1);
    n = 0;
    while ((beat_cnt - beat_base < 2) && (n < 20)) begin
      @(negedge clk);
      n++;
    end
    checkOutput("mid_two_beats", beat_cnt - beat_base, 2);
    #2 rst = 1'b0;
    #1;
    checkOutput("abort_wvalid", wvalid_le, 0);
    checkOutput("abort_wdata", wdata_le, 0);
    checkOutput("abort_wstrb", wstrb_le, 0);
    checkOutput("abort_wlast", wlast_le, 0);
    checkOutput("abort_busy", busy_le, 0);
    checkOutput("abort_ready", ready_le, 0);
    checkOutput("abort_done", done_le, 0);
    checkOutput("abort_wvalid_be", wvalid_be, 0);
    src_limit = src_taken;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("abort_no_done", done_cnt - done_base, 0);
    tab_d[0] = 32'h12345678; tab_b[0] = 4'hF;
    tab_d[1] = 32'h9ABCDEF0; tab_b[1] = 4'h5;
    applyStimulus(1, 2, 1'b1);
    waitDone(20);
    checkBurst("post_rst", 2, 2, 2);

    // Start during STREAM with a different length is ignored
    for (int k = 0; k < 4; k++) begin
      tab_d[k] = 32'h77000000 + k;
      tab_b[k] = 4'hF;
    end
    applyStimulus(3, 4, 1'b1);
    @(posedge clk);
    #1;
    start = 1'b1;
    burst_len = 8'd6;
    @(posedge clk);
    #1 start = 1'b0;
    waitDone(30);
    checkBurst("ign_start", 4, 4, 4);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
